// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the 64-point radix-2 DIF FFT: issues one butterfly
// per cycle over 6 stages, generates in-place addresses, twiddles, banks and done.
module fft_stage_sequencer #(
    parameter int unsigned BF_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy_o,
    output logic [2:0] stage_o,
    output logic       bf_valid_o,
    output logic [5:0] rd_addr_a_o,
    output logic [5:0] rd_addr_b_o,
    output logic [4:0] tw_idx_o,
    output logic       rd_bank_o,
    output logic       wr_en_o,
    output logic [5:0] wr_addr_a_o,
    output logic [5:0] wr_addr_b_o,
    output logic       wr_bank_o,
    output logic       done_o
);

    localparam int unsigned AW = 6;
    localparam int unsigned JW = 5;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 3;
    localparam int unsigned DW = 1 + 2 * AW + 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(5);
    localparam logic [JW-1:0] LAST_BF    = JW'(31);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_nx;
    logic [SW-1:0]   stage_nx;
    logic [JW-1:0]   j_q, j_nx;
    logic [CW-1:0]   drain_q, drain_nx;

    logic [SW-1:0]   shamt;
    logic [AW-1:0]   j_ext, span, pos, addr_a_nx, addr_b_nx;
    logic [JW-1:0]   tw_nx;

    logic [DW-1:0]   sr [BF_LATENCY];
    logic [DW-1:0]   sr_in;

    // Next-state, stage and butterfly counters
    always_comb begin
        state_nx = state_q;
        stage_nx = stage_o;
        j_nx     = j_q;
        drain_nx = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    stage_nx = '0;
                    j_nx     = '0;
                end
            end
            RUN: begin
                if (j_q == LAST_BF) begin
                    state_nx = DRAIN;
                    drain_nx = CW'(BF_LATENCY);
                end else begin
                    j_nx = j_q + JW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == CW'(1)) begin
                    if (stage_o == LAST_STAGE) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                        stage_nx = stage_o + SW'(1);
                        j_nx     = '0;
                    end
                end else begin
                    drain_nx = drain_q - CW'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // In-place address: insert a 0 bit into j at position (5-stage); b sets that bit
    always_comb begin
        shamt     = LAST_STAGE - stage_nx;
        j_ext     = AW'(j_nx);
        span      = AW'(1) << shamt;
        pos       = j_ext & (span - AW'(1));
        addr_a_nx = ((j_ext >> shamt) << (shamt + SW'(1))) | pos;
        addr_b_nx = addr_a_nx | span;
        tw_nx     = JW'(pos << stage_nx);
    end

    // Write-side payload; bank is forced low when nothing is issued
    assign sr_in = {bf_valid_o, rd_addr_a_o, rd_addr_b_o, bf_valid_o & ~rd_bank_o};
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_bank_o} = sr[BF_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            j_q         <= '0;
            drain_q     <= '0;
            stage_o     <= '0;
            busy_o      <= 1'b0;
            bf_valid_o  <= 1'b0;
            done_o      <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            tw_idx_o    <= '0;
            rd_bank_o   <= 1'b0;
            for (int i = 0; i < int'(BF_LATENCY); i++) begin
                sr[i] <= '0;
            end
        end else begin
            state_q    <= state_nx;
            j_q        <= j_nx;
            drain_q    <= drain_nx;
            busy_o     <= (state_nx != IDLE);
            bf_valid_o <= (state_nx == RUN);
            done_o     <= (state_nx == DONE);
            // Read-side fields hold their last value outside RUN
            if (state_nx == RUN) begin
                stage_o     <= stage_nx;
                rd_bank_o   <= stage_nx[0];
                rd_addr_a_o <= addr_a_nx;
                rd_addr_b_o <= addr_b_nx;
                tw_idx_o    <= tw_nx;
            end
            sr[0] <= sr_in;
            for (int i = 1; i < int'(BF_LATENCY); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

endmodule
